// File: rtl/leaf_out_packetizer_if.sv
// leaf_out_packetizer_if: user streams, routing/credit configuration and BFT link signals.
interface leaf_out_packetizer_if #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_OUT_PORTS = 6
);
  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic [NUM_OUT_PORTS-1:0] vld_user2interface;
  logic [NUM_OUT_PORTS-1:0] ack_interface2user;
  logic cfg_we;
  logic [NUM_PORT_BITS-1:0] cfg_port;
  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0] cfg_dest;
  logic credit_vld;
  logic [NUM_PORT_BITS-1:0] credit_port;
  logic [7:0] credit_cnt;
  logic resend;
  logic dout_ready;
  logic [PACKET_BITS-1:0] dout_leaf_interface2bft;
  logic [NUM_OUT_PORTS-1:0] credit_empty;
  modport master (
    output din_leaf_user2interface, vld_user2interface, cfg_we, cfg_port, cfg_dest,
           credit_vld, credit_port, credit_cnt, resend, dout_ready,
    input  ack_interface2user, dout_leaf_interface2bft, credit_empty
  );
  modport slave (
    input  din_leaf_user2interface, vld_user2interface, cfg_we, cfg_port, cfg_dest,
           credit_vld, credit_port, credit_cnt, resend, dout_ready,
    output ack_interface2user, dout_leaf_interface2bft, credit_empty
  );
endinterface

// File: rtl/leaf_out_packetizer.sv
// leaf_out_packetizer: per-port FIFOs, credit-gated round-robin arbitration and BFT packet register.
module leaf_out_packetizer #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS = 6,
  parameter int FIFO_DEPTH    = 4,
  parameter int CREDIT_INIT   = 64
) (
  input logic clk,
  input logic reset_n,
  leaf_out_packetizer_if.slave bus
);
  localparam int N  = NUM_OUT_PORTS;
  localparam int DB = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [PAYLOAD_BITS-1:0] mem [N][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [N];
  logic [AW-1:0] rd_ptr [N];
  logic [CW-1:0] count [N];
  logic [NUM_ADDR_BITS-1:0] seq [N];
  logic [7:0] credit [N];
  logic [7:0] credit_nxt [N];
  logic [8:0] credit_sum [N];
  logic [DB-1:0] dest [N];
  logic [N-1:0] route_vld, elig, room, push, pop;
  logic [IW-1:0] rr, grant;
  logic any, load;
  logic [PACKET_BITS-1:0] dout_q;

  assign push = bus.vld_user2interface & room & {N{reset_n}};
  assign bus.ack_interface2user = push;
  assign load = (!dout_q[PACKET_BITS-1] || bus.dout_ready) && !bus.resend;
  assign bus.dout_leaf_interface2bft = bus.resend ? '0 : dout_q;

  always_comb begin
    int idx;
    any = 1'b0;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      room[i] = count[i] < CW'(FIFO_DEPTH);
      elig[i] = count[i] != '0 && credit[i] != 8'd0 && route_vld[i];
    end
    // descending scan so the closest eligible port at or after rr wins
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(rr) + k;
      idx = (idx >= N) ? idx - N : idx;
      if (elig[idx]) begin
        any = 1'b1;
        grant = IW'(idx);
      end
    end
    for (int i = 0; i < N; i++) begin
      pop[i] = load && any && grant == IW'(i);
      credit_sum[i] = {1'b0, credit[i]} - {8'd0, pop[i]}
                    + ((bus.credit_vld && bus.credit_port == NUM_PORT_BITS'(i)) ? {1'b0, bus.credit_cnt} : 9'd0);
      credit_nxt[i] = credit_sum[i][8] ? 8'hff : credit_sum[i][7:0];
    end
  end

  always_ff @(posedge clk)
    for (int i = 0; i < N; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= bus.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        seq[i]    <= '0;
        credit[i] <= 8'(CREDIT_INIT);
        dest[i]   <= '0;
      end
      route_vld        <= '0;
      bus.credit_empty <= '0;
      rr               <= '0;
      dout_q           <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        wr_ptr[i] <= wr_ptr[i] + AW'(push[i]);
        rd_ptr[i] <= rd_ptr[i] + AW'(pop[i]);
        count[i]  <= count[i] + CW'(push[i]) - CW'(pop[i]);
        seq[i]    <= seq[i] + NUM_ADDR_BITS'(pop[i]);
        credit[i] <= credit_nxt[i];
        bus.credit_empty[i] <= credit_nxt[i] == 8'd0;
        if (bus.cfg_we && bus.cfg_port == NUM_PORT_BITS'(i)) begin
          dest[i]      <= bus.cfg_dest;
          route_vld[i] <= 1'b1;
        end
      end
      if (load) dout_q <= any ? {1'b1, dest[grant], seq[grant], mem[grant][rd_ptr[grant]]} : '0;
      if (load && any) rr <= (grant == IW'(N - 1)) ? '0 : grant + 1'b1;
    end
endmodule
